move_validator: RTL and testbench

//  Registered move-acceptance engine for an N-cell board. It holds both players' occupancy

---
 rtl/move_validator.sv | 159 +++++++++++++++
 tb/tb_move_validator.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_validator.sv
// ============================================================================
// Module      : move_validator
// Description : Registered move-acceptance engine for an N-cell two-player
//               board. Checks range, board-full and occupancy, then commits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_validator #(
    parameter int CELLS = 9,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             move_valid,
    input  logic [IDX_W-1:0] move_idx,
    output logic             move_ready,
    output logic             accept,
    output logic             reject,
    output logic [1:0]       reject_code,
    output logic [CELLS-1:0] p1_board,
    output logic [CELLS-1:0] p2_board,
    output logic             turn,
    output logic [6:0]       move_count,
    output logic             board_full,
    output logic             conflict
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] C_CODE_OK    = 2'b00;
    localparam logic [1:0] C_CODE_OCC   = 2'b01;
    localparam logic [1:0] C_CODE_RANGE = 2'b10;
    localparam logic [1:0] C_CODE_FULL  = 2'b11;
    localparam logic [6:0] C_CELLS_CNT  = 7'(CELLS);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_player;
    logic [CELLS-1:0] r_p1;
    logic [CELLS-1:0] r_p2;
    logic             r_turn;
    logic [6:0]       r_count;
    logic             r_accept;
    logic             r_reject;
    logic [1:0]       r_code;

    logic [CELLS-1:0] w_onehot;
    logic             w_in_range;
    logic             w_occupied;
    logic             w_full;
    logic [1:0]       w_code;

    assign w_onehot   = {{(CELLS-1){1'b0}}, 1'b1} << r_idx;
    assign w_in_range = ({{(32-IDX_W){1'b0}}, r_idx} < 32'(CELLS));
    assign w_occupied = |((r_p1 | r_p2) & w_onehot);
    assign w_full     = (r_count == C_CELLS_CNT);

    // Range is tested first so the occupancy lookup never depends on a
    // truncated one-hot for an index beyond the board.
    always_comb begin
        w_code = C_CODE_OK;
        if (!w_in_range) begin
            w_code = C_CODE_RANGE;
        end else if (w_full) begin
            w_code = C_CODE_FULL;
        end else if (w_occupied) begin
            w_code = C_CODE_OCC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (move_valid) w_next_state = S_CHECK;
            S_CHECK: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (clear) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_player <= 1'b0;
        end else if (r_state == S_IDLE && move_valid) begin
            r_idx    <= move_idx;
            r_player <= r_turn;
        end
    end

    // Board update lands on the CHECK->RESP edge so it is visible with accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1     <= '0;
            r_p2     <= '0;
            r_turn   <= 1'b0;
            r_count  <= '0;
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            r_code   <= C_CODE_OK;
        end else begin
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            if (clear) begin
                r_p1    <= '0;
                r_p2    <= '0;
                r_turn  <= 1'b0;
                r_count <= '0;
                r_code  <= C_CODE_OK;
            end else if (r_state == S_CHECK) begin
                if (w_code == C_CODE_OK) begin
                    r_accept <= 1'b1;
                    if (r_player) begin
                        r_p2 <= r_p2 | w_onehot;
                    end else begin
                        r_p1 <= r_p1 | w_onehot;
                    end
                    r_turn  <= ~r_turn;
                    r_count <= r_count + 7'd1;
                end else begin
                    r_reject <= 1'b1;
                    r_code   <= w_code;
                end
            end
        end
    end

    assign move_ready  = (r_state == S_IDLE);
    assign accept      = r_accept;
    assign reject      = r_reject;
    assign reject_code = r_code;
    assign p1_board    = r_p1;
    assign p2_board    = r_p2;
    assign turn        = r_turn;
    assign move_count  = r_count;
    assign board_full  = w_full;
    assign conflict    = |(r_p1 & r_p2);

endmodule

`default_nettype wire

// File: tb/tb_move_validator.sv
// ============================================================================
// Module      : tb_move_validator
// Description : Drives a 9-cell and a 16-cell move_validator with identical
//               stimulus and compares both against a game-rules model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_validator;

    typedef logic [142:0] vec_t;

    logic clk;
    logic rst;
    logic clear;
    logic move_valid;
    logic [3:0] move_idx;

    logic [1:0]       d_ready, d_acc, d_rej, d_turn, d_full, d_conf;
    logic [1:0][1:0]  d_code;
    logic [1:0][6:0]  d_cnt;
    logic [8:0]       p1_9, p2_9;
    logic [15:0]      p1_16, p2_16;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_cells [2] = '{9, 16};
    logic [63:0] m_p1    [2];
    logic [63:0] m_p2    [2];
    logic        m_turn  [2];
    int          m_cnt   [2];
    logic [1:0]  m_code  [2];

    move_validator #(.CELLS(9), .IDX_W(4)) u_dut9 (
        .clk(clk), .rst(rst), .clear(clear), .move_valid(move_valid), .move_idx(move_idx),
        .move_ready(d_ready[0]), .accept(d_acc[0]), .reject(d_rej[0]), .reject_code(d_code[0]),
        .p1_board(p1_9), .p2_board(p2_9), .turn(d_turn[0]), .move_count(d_cnt[0]),
        .board_full(d_full[0]), .conflict(d_conf[0])
    );

    move_validator #(.CELLS(16), .IDX_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .clear(clear), .move_valid(move_valid), .move_idx(move_idx),
        .move_ready(d_ready[1]), .accept(d_acc[1]), .reject(d_rej[1]), .reject_code(d_code[1]),
        .p1_board(p1_16), .p2_board(p2_16), .turn(d_turn[1]), .move_count(d_cnt[1]),
        .board_full(d_full[1]), .conflict(d_conf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_p1[k]   = '0;
            m_p2[k]   = '0;
            m_turn[k] = 1'b0;
            m_cnt[k]  = 0;
            m_code[k] = 2'b00;
        end
    endfunction

    // Game rules: returns 0 when the move is legal, otherwise the refusal code.
    function automatic logic [1:0] model_move(int k, int idx);
        logic [1:0] r;
        if (idx >= m_cells[k])                  r = 2'b10;
        else if (m_cnt[k] == m_cells[k])        r = 2'b11;
        else if (m_p1[k][idx] || m_p2[k][idx])  r = 2'b01;
        else                                    r = 2'b00;
        if (r != 2'b00) begin
            m_code[k] = r;
        end else begin
            if (m_turn[k]) m_p2[k][idx] = 1'b1;
            else           m_p1[k][idx] = 1'b1;
            m_turn[k] = ~m_turn[k];
            m_cnt[k]  = m_cnt[k] + 1;
        end
        return r;
    endfunction

    function automatic vec_t exp_vec(int k, logic acc, logic rej, logic rdy);
        return {acc, rej, m_code[k], m_turn[k], 7'(m_cnt[k]), (m_cnt[k] == m_cells[k]),
                1'b0, rdy, m_p1[k], m_p2[k]};
    endfunction

    function automatic vec_t obs_vec(int k);
        logic [63:0] p1, p2;
        p1 = (k == 0) ? 64'(p1_9) : 64'(p1_16);
        p2 = (k == 0) ? 64'(p2_9) : 64'(p2_16);
        return {d_acc[k], d_rej[k], d_code[k], d_turn[k], d_cnt[k], d_full[k], d_conf[k],
                d_ready[k], p1, p2};
    endfunction

    // Issues one request and returns at the response cycle (+1 time unit).
    task automatic issue(input int idx, output logic [1:0][1:0] res);
        int waited = 0;
        @(negedge clk);
        while (!d_ready[0] && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!d_ready[0]) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout got move_ready=%b required 1", d_ready[0]);
        end
        move_valid = 1'b1;
        move_idx   = 4'(idx);
        @(posedge clk);
        res[0] = model_move(0, idx);
        res[1] = model_move(1, idx);
        @(negedge clk);
        move_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; move_valid = 1'b0; move_idx = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0, 1'b1)) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b0, 1'b1));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0, 1'b1)) begin
                n_fail++;
                $display("FAIL reset_release inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b0, 1'b1));
            end
        end
    endtask

    // Scenarios: first move, occupied cell, out of range, full board.
    task automatic test_directed();
        int seq [$] = '{-1, 4, -1, 0, 0, 9, 15, -1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 3};
        logic [1:0][1:0] res;
        foreach (seq[s]) begin
            if (seq[s] < 0) begin
                do_clear();
                continue;
            end
            issue(seq[s], res);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0)) begin
                    n_fail++;
                    $display("FAIL directed_resp step=%0d idx=%0d inst=%0d got=%h exp=%h", s, seq[s], k,
                             obs_vec(k), exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0));
                end
            end
            if (s == 1) begin
                n_checks++;
                if (p1_9 !== 9'h010 || p1_16 !== 16'h0010 || d_turn !== 2'b11 || d_acc !== 2'b11) begin
                    n_fail++;
                    $display("FAIL first_move got p1=%h/%h turn=%b acc=%b required 010/0010 11 11", p1_9, p1_16, d_turn, d_acc);
                end
            end
            if (s == 4) begin
                n_checks++;
                if (d_code !== 4'b0101 || d_rej !== 2'b11 || p2_9 !== 9'h000 || d_cnt[0] !== 7'd1) begin
                    n_fail++;
                    $display("FAIL occupied got code=%b rej=%b p2=%h cnt=%0d required 0101 11 000 1", d_code, d_rej, p2_9, d_cnt[0]);
                end
            end
            if (s == 16) begin
                n_checks++;
                if (p1_9 !== 9'h155 || p2_9 !== 9'h0AA || d_full[0] !== 1'b1 || d_cnt[0] !== 7'd9) begin
                    n_fail++;
                    $display("FAIL full_pattern got p1=%h p2=%h full=%b cnt=%0d required 155 0AA 1 9", p1_9, p2_9, d_full[0], d_cnt[0]);
                end
            end
            if (s == 24) begin
                n_checks++;
                if (d_code !== 4'b1111 || d_rej !== 2'b11 || d_full !== 2'b11) begin
                    n_fail++;
                    $display("FAIL full_reject got code=%b rej=%b full=%b required 1111 11 11", d_code, d_rej, d_full);
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0, 1'b1)) begin
                    n_fail++;
                    $display("FAIL pulse_width step=%0d inst=%0d got=%h exp=%h", s, k, obs_vec(k), exp_vec(k, 1'b0, 1'b0, 1'b1));
                end
            end
        end
    endtask

    task automatic test_clear_in_check();
        logic [1:0][1:0] res;
        do_clear();
        issue(2, res);
        issue(5, res);
        @(negedge clk);
        move_valid = 1'b1;
        move_idx   = 4'd7;
        @(negedge clk);
        move_valid = 1'b0;
        clear      = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0, 1'b1)) begin
                n_fail++;
                $display("FAIL clear_in_check inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b0, 1'b1));
            end
        end
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0, 1'b1)) begin
                n_fail++;
                $display("FAIL clear_no_pulse inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_rst_in_resp();
        logic [1:0][1:0] res;
        do_clear();
        issue(1, res);
        #1;
        rst = 1'b1;
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0, 1'b1)) begin
                n_fail++;
                $display("FAIL rst_in_resp inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b0, 1'b1));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k, 1'b0, 1'b0, 1'b1)) begin
                n_fail++;
                $display("FAIL rst_discard inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k, 1'b0, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0][1:0] res;
        int idx;
        do_clear();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                do_clear();
                continue;
            end
            idx = int'($urandom_range(0, 15));
            issue(idx, res);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0)) begin
                    n_fail++;
                    $display("FAIL random_resp iter=%0d idx=%0d inst=%0d got=%h exp=%h", i, idx, k,
                             obs_vec(k), exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0));
                end
            end
        end
    endtask

    // move_valid held high: captures must come exactly every third cycle.
    task automatic test_back_to_back();
        logic [1:0][1:0] res;
        logic ready_seen;
        logic pending = 1'b0;
        int   idx_now;
        int   last_cap = -1;
        int   captures = 0;
        do_clear();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ready_seen = d_ready[0];
            idx_now    = int'($urandom_range(0, 15));
            move_valid = 1'b1;
            move_idx   = 4'(idx_now);
            @(posedge clk);
            #1;
            if (pending) begin
                pending = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (obs_vec(k) !== exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0)) begin
                        n_fail++;
                        $display("FAIL b2b_resp cyc=%0d inst=%0d got=%h exp=%h", i, k,
                                 obs_vec(k), exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0));
                    end
                end
            end
            n_checks++;
            if (d_conf !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b_conflict cyc=%0d got=%b required 00", i, d_conf);
            end
            if (ready_seen) begin
                res[0] = model_move(0, idx_now);
                res[1] = model_move(1, idx_now);
                pending = 1'b1;
                if (last_cap >= 0) begin
                    n_checks++;
                    if (i - last_cap != 3) begin
                        n_fail++;
                        $display("FAIL b2b_gap cyc=%0d got=%0d required 3", i, i - last_cap);
                    end
                end
                last_cap = i;
                captures++;
            end
        end
        @(negedge clk);
        move_valid = 1'b0;
        @(posedge clk);
        #1;
        if (pending) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_last inst=%0d got=%h exp=%h", k, obs_vec(k),
                             exp_vec(k, res[k] == 2'b00, res[k] != 2'b00, 1'b0));
                end
            end
        end
        n_checks++;
        if (captures != 10) begin
            n_fail++;
            $display("FAIL b2b_captures got=%0d required 10", captures);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clear_in_check();
        test_rst_in_resp();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
